hazard_fwd_unit: RTL and testbench

- Hazard and forwarding control for the 5-stage LoongArch pipeline. Sits in ID and tracks the destination registers of the instructions in EX and MEM.
- Produces registered forward selects that enter EX alongside the operands and drive the EX-stage operand muxes: forwardEX picks the EX/MEM ALU result, forwardMEM picks the WB-stage dm data.
- Also generates the load-use stall and the branch-flush bubble, and keeps saturating stall/flush counters.

---
 rtl/hazard_fwd_unit_if.sv | 47 ++++
 rtl/hazard_fwd_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// ============================================================================
// Module      : hazard_fwd_unit_if
// Description : ID-stage operand/destination bundle and hazard/forward results.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface hazard_fwd_unit_if #(
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               pipe_hold;
  logic               id_valid;
  logic [RADDR_W-1:0] id_rs1_addr;
  logic               id_rs1_used;
  logic [RADDR_W-1:0] id_rs2_addr;
  logic               id_rs2_used;
  logic [RADDR_W-1:0] id_rd_addr;
  logic               id_rd_we;
  logic               id_is_load;
  logic               ex_branch_taken;

  logic               stall_id;
  logic               ex_fwd1_ex;
  logic               ex_fwd1_mem;
  logic               ex_fwd2_ex;
  logic               ex_fwd2_mem;
  logic               ex_valid;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output pipe_hold, id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr,
           id_rs2_used, id_rd_addr, id_rd_we, id_is_load, ex_branch_taken,
    input  stall_id, ex_fwd1_ex, ex_fwd1_mem, ex_fwd2_ex, ex_fwd2_mem,
           ex_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  pipe_hold, id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr,
           id_rs2_used, id_rd_addr, id_rd_we, id_is_load, ex_branch_taken,
    output stall_id, ex_fwd1_ex, ex_fwd1_mem, ex_fwd2_ex, ex_fwd2_mem,
           ex_valid, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Load-use stall, branch flush and EX/WB forward-select control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit #(
  parameter int CNT_W   = 16,
  parameter int RADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_unit_if.slave  bus
);

  logic               ex_v_q,   ex_v_d;
  logic [RADDR_W-1:0] ex_rd_q,  ex_rd_d;
  logic               ex_we_q,  ex_we_d;
  logic               ex_ld_q,  ex_ld_d;
  logic               mem_v_q,  mem_v_d;
  logic [RADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic               mem_we_q, mem_we_d;

  logic               fwd1_ex_q,  fwd1_ex_d;
  logic               fwd1_mem_q, fwd1_mem_d;
  logic               fwd2_ex_q,  fwd2_ex_d;
  logic               fwd2_mem_q, fwd2_mem_d;
  logic               ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic m1_ex, m2_ex, m1_mem, m2_mem, stall;

  // A source matches a slot only when it is genuinely read and is not $r0.
  function automatic logic src_match(
    input logic               rs_used,
    input logic [RADDR_W-1:0] rs,
    input logic               slot_v,
    input logic               slot_we,
    input logic [RADDR_W-1:0] slot_rd
  );
    return bus.id_valid & rs_used & (rs != '0) & slot_v & slot_we & (slot_rd == rs);
  endfunction

  always_comb begin
    m1_ex  = src_match(bus.id_rs1_used, bus.id_rs1_addr, ex_v_q,  ex_we_q,  ex_rd_q);
    m2_ex  = src_match(bus.id_rs2_used, bus.id_rs2_addr, ex_v_q,  ex_we_q,  ex_rd_q);
    m1_mem = src_match(bus.id_rs1_used, bus.id_rs1_addr, mem_v_q, mem_we_q, mem_rd_q);
    m2_mem = src_match(bus.id_rs2_used, bus.id_rs2_addr, mem_v_q, mem_we_q, mem_rd_q);
    stall  = (m1_ex | m2_ex) & ex_ld_q & ~bus.ex_branch_taken;
  end

  always_comb begin
    ex_v_d      = ex_v_q;
    ex_rd_d     = ex_rd_q;
    ex_we_d     = ex_we_q;
    ex_ld_d     = ex_ld_q;
    mem_v_d     = mem_v_q;
    mem_rd_d    = mem_rd_q;
    mem_we_d    = mem_we_q;
    fwd1_ex_d   = fwd1_ex_q;
    fwd1_mem_d  = fwd1_mem_q;
    fwd2_ex_d   = fwd2_ex_q;
    fwd2_mem_d  = fwd2_mem_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!bus.pipe_hold) begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_we_d = ex_we_q;

      if (bus.ex_branch_taken || stall) begin
        // Bubble into EX; the older instruction still drains into MEM.
        ex_v_d     = 1'b0;
        ex_rd_d    = '0;
        ex_we_d    = 1'b0;
        ex_ld_d    = 1'b0;
        fwd1_ex_d  = 1'b0;
        fwd1_mem_d = 1'b0;
        fwd2_ex_d  = 1'b0;
        fwd2_mem_d = 1'b0;
        ex_valid_d = 1'b0;
        if (bus.ex_branch_taken) begin
          if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
          if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end else begin
        ex_v_d     = bus.id_valid;
        ex_rd_d    = bus.id_rd_addr;
        ex_we_d    = bus.id_rd_we & bus.id_valid;
        ex_ld_d    = bus.id_is_load & bus.id_valid;
        ex_valid_d = bus.id_valid;
        fwd1_ex_d  = m1_ex;
        fwd1_mem_d = m1_mem & ~m1_ex;
        fwd2_ex_d  = m2_ex;
        fwd2_mem_d = m2_mem & ~m2_ex;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      fwd1_ex_q   <= 1'b0;
      fwd1_mem_q  <= 1'b0;
      fwd2_ex_q   <= 1'b0;
      fwd2_mem_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      fwd1_ex_q   <= fwd1_ex_d;
      fwd1_mem_q  <= fwd1_mem_d;
      fwd2_ex_q   <= fwd2_ex_d;
      fwd2_mem_q  <= fwd2_mem_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_id    = stall;
  assign bus.ex_fwd1_ex  = fwd1_ex_q;
  assign bus.ex_fwd1_mem = fwd1_mem_q;
  assign bus.ex_fwd2_ex  = fwd2_ex_q;
  assign bus.ex_fwd2_mem = fwd2_mem_q;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// Module      : tb_hazard_fwd_unit
// Description : Directed checks of hazard_fwd_unit (16-bit and 2-bit counters).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.RADDR_W(5), .CNT_W(16)) bus ();
  hazard_fwd_unit_if #(.RADDR_W(5), .CNT_W(2))  bus2 ();

  hazard_fwd_unit #(.CNT_W(16), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_fwd_unit #(.CNT_W(2),  .RADDR_W(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.pipe_hold       = bus.pipe_hold;
  assign bus2.id_valid        = bus.id_valid;
  assign bus2.id_rs1_addr     = bus.id_rs1_addr;
  assign bus2.id_rs1_used     = bus.id_rs1_used;
  assign bus2.id_rs2_addr     = bus.id_rs2_addr;
  assign bus2.id_rs2_used     = bus.id_rs2_used;
  assign bus2.id_rd_addr      = bus.id_rd_addr;
  assign bus2.id_rd_we        = bus.id_rd_we;
  assign bus2.id_is_load      = bus.id_is_load;
  assign bus2.ex_branch_taken = bus.ex_branch_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs packed {fwd1_ex, fwd1_mem, fwd2_ex, fwd2_mem, ex_valid}.
  task automatic chk_ex(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, bus.ex_fwd1_ex, bus.ex_fwd1_mem, bus.ex_fwd2_ex,
              bus.ex_fwd2_mem, bus.ex_valid}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld);
    bus.id_valid    = v;
    bus.id_rs1_addr = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2_addr = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd_addr  = rd;
    bus.id_rd_we    = we;
    bus.id_is_load  = ld;
  endtask

  task automatic drain();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, {31'd0, bus.stall_id}, {31'd0, exp});
  endtask

  initial begin
    bus.pipe_hold       = 1'b0;
    bus.ex_branch_taken = 1'b0;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk_ex("reset_ex", 5'b00000);
    chk("reset_stall", {31'd0, bus.stall_id}, 32'd0);
    chk("reset_scnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("reset_fcnt", {16'd0, bus.flush_cnt}, 32'd0);

    // add r5,r1,r2 ; sub r6,r5,r5
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    chk_ex("add_in_ex", 5'b00001);
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    chk_stall("alu_chain_stall", 1'b0);
    tick();
    chk_ex("alu_chain_fwd", 5'b10101);
    drain();

    // r7 written at distance 2 and distance 1: nearer producer wins
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    chk_ex("nearer_wins", 5'b10001);
    drain();

    // r7 written only at distance 2
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    chk_ex("dist2_mem", 5'b00011);
    drain();

    // ld.w r4 ; add r8,r4,r0
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk_stall("lu_stall_on", 1'b1);
    tick();
    chk_ex("lu_bubble", 5'b00000);
    chk("lu_scnt", {16'd0, bus.stall_cnt}, 32'd1);
    chk_stall("lu_stall_off", 1'b0);
    tick();
    chk_ex("lu_retry_fwdmem", 5'b01001);
    drain();

    // flush coincident with a load-use condition
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b1;
    chk_stall("flush_no_stall", 1'b0);
    tick();
    bus.ex_branch_taken = 1'b0;
    chk_ex("flush_bubble", 5'b00000);
    chk("flush_fcnt", {16'd0, bus.flush_cnt}, 32'd1);
    chk("flush_scnt", {16'd0, bus.stall_cnt}, 32'd1);
    drain();

    // $r0 destination of a load never stalls or forwards
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk_stall("r0_no_stall", 1'b0);
    tick();
    chk_ex("r0_no_fwd", 5'b00001);
    drain();

    // pipe_hold for 3 cycles during a stall
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.pipe_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_stall("hold_stall", 1'b1);
      tick();
      chk_ex("hold_ex_frozen", 5'b00001);
      chk("hold_scnt", {16'd0, bus.stall_cnt}, 32'd1);
    end
    bus.pipe_hold = 1'b0;
    chk_stall("hold_release_stall", 1'b1);
    tick();
    chk_ex("hold_bubble", 5'b00000);
    chk("hold_scnt_inc", {16'd0, bus.stall_cnt}, 32'd2);
    tick();
    chk_ex("hold_retry_fwd", 5'b00011);
    drain();

    // four more load-use stalls: 16-bit counter reaches 6, 2-bit saturates at 3
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
    chk("sat_scnt16", {16'd0, bus.stall_cnt}, 32'd6);
    chk("sat_scnt2", {30'd0, bus2.stall_cnt}, 32'd3);
    chk("sat_fcnt2", {30'd0, bus2.flush_cnt}, 32'd1);
    drain();

    // asynchronous reset mid-cycle while a stall is active
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, bus.stall_id}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, bus.stall_id}, 32'd0);
    chk_ex("arst_ex", 5'b00000);
    chk("arst_scnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("arst_fcnt", {16'd0, bus.flush_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    chk_stall("post_rst_stall", 1'b0);
    tick();
    chk_ex("post_rst_nofwd", 5'b00001);
    chk("post_rst_scnt", {16'd0, bus.stall_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
